// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers for the serial engine and the
//               register wrapper.
// Revision    : 1.0 - initial release
// =============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_e;

    localparam logic [1:0] c_data_bits_5 = 2'd0;
    localparam logic [1:0] c_data_bits_6 = 2'd1;
    localparam logic [1:0] c_data_bits_7 = 2'd2;
    localparam logic [1:0] c_data_bits_8 = 2'd3;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP1  = 3'd4,
        TX_STOP2  = 3'd5
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Encoding 2'b11 is reserved and behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return EVEN;
            2'b10:   return ODD;
            default: return NONE;
        endcase
    endfunction

    function automatic logic [2:0] last_bit_index(input logic [1:0] bits);
        return {1'b0, bits} + 3'd4;
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] bits);
        return 8'hFF >> (3'd3 - {1'b0, bits});
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_if.sv
`default_nettype none
// =============================================================================
// Module      : uart_if
// Description : Configuration, TX/RX handshake and serial pins of the engine.
// Revision    : 1.0 - initial release
// =============================================================================
interface uart_if #(
    parameter int DIV_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] cfg_divisor;
    logic [1:0]           cfg_data_bits;
    logic [1:0]           cfg_parity;
    logic                 cfg_stop2;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx;
    logic                 rx;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output cfg_divisor, cfg_data_bits, cfg_parity, cfg_stop2,
        output tx_data, tx_valid, rx,
        input  tx_ready, tx_busy, tx,
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  cfg_divisor, cfg_data_bits, cfg_parity, cfg_stop2,
        input  tx_data, tx_valid, rx,
        output tx_ready, tx_busy, tx,
        output rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// =============================================================================
// Module      : uart_baud_gen
// Description : Free-running divisor counter producing the oversample tick.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [DIV_WIDTH-1:0] i_divisor,
    output logic                      o_tick
);
    logic [DIV_WIDTH-1:0] r_count;

    // >= keeps the counter from running the full range if the divisor shrinks.
    assign o_tick = (r_count >= i_divisor);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// =============================================================================
// Module      : uart_core
// Description : Full-duplex UART engine: 5-8 data bits, optional parity,
//               1/2 TX stop bits, oversampled RX with glitch rejection.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_core #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    uart_if.slave     bus
);
    import uart_pkg::*;

    localparam int                c_ph_w    = $clog2(OVERSAMPLE);
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(OVERSAMPLE - 1);
    localparam logic [c_ph_w-1:0] c_ph_half = c_ph_w'(OVERSAMPLE / 2 - 1);

    logic w_tick;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud_gen (
        .clk      (clk),
        .rst      (reset),
        .i_divisor(bus.cfg_divisor),
        .o_tick   (w_tick)
    );

    // ---------------------------------------------------------------- TX
    tx_state_e         r_tx_state;
    logic [c_ph_w-1:0] r_tx_phase;
    logic [7:0]        r_tx_shift;
    logic [2:0]        r_tx_idx;
    logic [2:0]        r_tx_last;
    logic              r_tx_par_en;
    logic              r_tx_par_bit;
    logic              r_tx_stop2;
    logic              r_tx;

    parity_e    w_tx_par;
    logic [7:0] w_tx_masked;
    logic       w_tx_accept;
    logic       w_tx_bit_end;

    assign w_tx_par     = decode_parity(bus.cfg_parity);
    assign w_tx_masked  = bus.tx_data & data_mask(bus.cfg_data_bits);
    assign w_tx_accept  = bus.tx_valid && (r_tx_state == TX_IDLE);
    assign w_tx_bit_end = w_tick && (r_tx_phase == c_ph_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_phase   <= '0;
            r_tx_shift   <= '0;
            r_tx_idx     <= '0;
            r_tx_last    <= '0;
            r_tx_par_en  <= 1'b0;
            r_tx_par_bit <= 1'b0;
            r_tx_stop2   <= 1'b0;
            r_tx         <= 1'b1;
        end else if (r_tx_state == TX_IDLE) begin
            if (w_tx_accept) begin
                r_tx_state   <= TX_START;
                r_tx_phase   <= '0;
                r_tx_shift   <= w_tx_masked;
                r_tx_idx     <= '0;
                r_tx_last    <= last_bit_index(bus.cfg_data_bits);
                r_tx_par_en  <= (w_tx_par != NONE);
                r_tx_par_bit <= (w_tx_par == ODD) ^ (^w_tx_masked);
                r_tx_stop2   <= bus.cfg_stop2;
                r_tx         <= 1'b0;
            end
        end else begin
            // Phase counter wraps naturally because OVERSAMPLE is a power of two.
            if (w_tick) begin
                r_tx_phase <= r_tx_phase + 1'b1;
            end
            if (w_tx_bit_end) begin
                case (r_tx_state)
                    TX_START: begin
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                    end
                    TX_DATA: begin
                        if (r_tx_idx == r_tx_last) begin
                            r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP1;
                            r_tx       <= r_tx_par_en ? r_tx_par_bit : 1'b1;
                        end else begin
                            r_tx_idx   <= r_tx_idx + 3'd1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                    TX_PARITY: begin
                        r_tx_state <= TX_STOP1;
                        r_tx       <= 1'b1;
                    end
                    TX_STOP1: begin
                        r_tx_state <= r_tx_stop2 ? TX_STOP2 : TX_IDLE;
                        r_tx       <= 1'b1;
                    end
                    default: begin
                        r_tx_state <= TX_IDLE;
                        r_tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx_ready = (r_tx_state == TX_IDLE);
    assign bus.tx_busy  = (r_tx_state != TX_IDLE);
    assign bus.tx       = r_tx;

    // ---------------------------------------------------------------- RX
    logic              r_sync1;
    logic              r_sync2;
    rx_state_e         r_rx_state;
    logic [c_ph_w-1:0] r_rx_phase;
    logic [2:0]        r_rx_idx;
    logic [2:0]        r_rx_last;
    parity_e           r_rx_par;
    logic              r_rx_par_acc;
    logic              r_rx_par_err;
    logic              r_rx_armed;
    logic [7:0]        r_rx_shift;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_rx_parity_err;
    logic              r_rx_frame_err;

    logic w_rx_in;
    logic w_rx_sample;

    assign w_rx_in     = r_sync2;
    assign w_rx_sample = w_tick && (r_rx_phase == c_ph_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1         <= 1'b1;
            r_sync2         <= 1'b1;
            r_rx_state      <= RX_IDLE;
            r_rx_phase      <= '0;
            r_rx_idx        <= '0;
            r_rx_last       <= '0;
            r_rx_par        <= NONE;
            r_rx_par_acc    <= 1'b0;
            r_rx_par_err    <= 1'b0;
            r_rx_armed      <= 1'b1;
            r_rx_shift      <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_rx_parity_err <= 1'b0;
            r_rx_frame_err  <= 1'b0;
        end else begin
            r_sync1    <= bus.rx;
            r_sync2    <= r_sync1;
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    // A line still low after a frame (break) must go high before re-arming.
                    if (w_rx_in) begin
                        r_rx_armed <= 1'b1;
                    end else if (r_rx_armed) begin
                        r_rx_state   <= RX_START;
                        r_rx_phase   <= '0;
                        r_rx_idx     <= '0;
                        r_rx_shift   <= '0;
                        r_rx_par_acc <= 1'b0;
                        r_rx_par_err <= 1'b0;
                        r_rx_last    <= last_bit_index(bus.cfg_data_bits);
                        r_rx_par     <= decode_parity(bus.cfg_parity);
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        r_rx_phase <= r_rx_phase + 1'b1;
                        if (r_rx_phase == c_ph_half) begin
                            r_rx_phase <= '0;
                            r_rx_state <= w_rx_in ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_rx_phase <= r_rx_phase + 1'b1;
                    end
                    if (w_rx_sample) begin
                        case (r_rx_state)
                            RX_DATA: begin
                                r_rx_shift[r_rx_idx] <= w_rx_in;
                                r_rx_par_acc         <= r_rx_par_acc ^ w_rx_in;
                                if (r_rx_idx == r_rx_last) begin
                                    r_rx_state <= (r_rx_par != NONE) ? RX_PARITY : RX_STOP;
                                end else begin
                                    r_rx_idx <= r_rx_idx + 3'd1;
                                end
                            end
                            RX_PARITY: begin
                                r_rx_par_err <= r_rx_par_acc ^ w_rx_in ^ (r_rx_par == ODD);
                                r_rx_state   <= RX_STOP;
                            end
                            RX_STOP: begin
                                r_rx_valid      <= 1'b1;
                                r_rx_data       <= r_rx_shift;
                                r_rx_parity_err <= r_rx_par_err;
                                r_rx_frame_err  <= ~w_rx_in;
                                r_rx_armed      <= 1'b0;
                                r_rx_state      <= RX_IDLE;
                            end
                            default: begin
                                r_rx_state <= RX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_parity_err;
    assign bus.rx_frame_err  = r_rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// =============================================================================
// Module      : tb_uart_core
// Description : Self-checking bench for uart_core against a frame-level model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_uart_core;

    logic clk = 1'b0;
    logic reset;
    logic loopback;
    logic rx_drv;

    always #5 clk = ~clk;

    uart_if #(.DIV_WIDTH(16)) u_if ();

    assign u_if.rx = loopback ? u_if.tx : rx_drv;

    uart_core #(.DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         pulses;
    logic [7:0] got_data;
    logic       got_pe;
    logic       got_fe;
    bit         frame_q[$];

    // Line levels of one frame, one entry per bit period.
    function automatic void build_frame(input logic [7:0] d, input int nbits,
                                        input int par, input bit stop2);
        bit p;
        p = 1'b0;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            frame_q.push_back(d[i]);
            p ^= d[i];
        end
        if (par == 1) frame_q.push_back(p);
        else if (par == 2) frame_q.push_back(~p);
        frame_q.push_back(1'b1);
        if (stop2) frame_q.push_back(1'b1);
    endfunction

    function automatic logic [7:0] expect_data(input logic [7:0] d, input int nbits);
        return d & 8'((1 << nbits) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (u_if.rx_valid === 1'b1) begin
            pulses++;
            got_data = u_if.rx_data;
            got_pe   = u_if.rx_parity_err;
            got_fe   = u_if.rx_frame_err;
        end
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic [1:0] par, input logic stop2);
        u_if.cfg_data_bits = bits;
        u_if.cfg_parity    = par;
        u_if.cfg_stop2     = stop2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] bits,
                              input logic [1:0] par, input logic stop2, input bit expect_rx);
        int nb;
        int len;
        nb = int'(bits) + 5;
        build_frame(d, nb, int'(par), stop2);
        len = frame_q.size() * 16;
        pulses = 0;
        set_cfg(bits, par, stop2);
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        for (int k = 1; k <= len; k++) begin
            tick();
            if (k == 1) begin
                // Disturb the inputs after the handshake; the frame must not change.
                u_if.tx_valid  = 1'b0;
                u_if.tx_data   = 8'($urandom);
                u_if.cfg_stop2 = 1'($urandom);
                if (!expect_rx) begin
                    u_if.cfg_data_bits = 2'($urandom);
                    u_if.cfg_parity    = 2'($urandom);
                end
            end
            chk("tx_bit", 32'(u_if.tx), 32'(frame_q[(k - 1) / 16]));
        end
        chk("tx_busy_last_cycle", 32'(u_if.tx_busy), 32'd1);
        tick();
        chk("tx_ready_after_frame", 32'(u_if.tx_ready), 32'd1);
        chk("tx_busy_after_frame", 32'(u_if.tx_busy), 32'd0);
        repeat (20) tick();
        chk("rx_pulse_count", 32'(pulses), expect_rx ? 32'd1 : 32'd0);
        if (expect_rx) begin
            chk("loop_rx_data", 32'(got_data), 32'(expect_data(d, nb)));
            chk("loop_parity_err", 32'(got_pe), 32'd0);
            chk("loop_frame_err", 32'(got_fe), 32'd0);
        end
    endtask

    task automatic rx_frame(input int lead_high, input int hold_low);
        pulses = 0;
        rx_drv = 1'b1;
        repeat (lead_high) tick();
        foreach (frame_q[i]) begin
            rx_drv = frame_q[i];
            repeat (16) tick();
        end
        if (hold_low > 0) begin
            rx_drv = 1'b0;
            repeat (hold_low) tick();
        end
        rx_drv = 1'b1;
        repeat (40) tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         dur;
        int         len;

        reset              = 1'b1;
        loopback           = 1'b0;
        rx_drv             = 1'b1;
        u_if.tx_valid      = 1'b0;
        u_if.tx_data       = 8'h00;
        u_if.cfg_divisor   = 16'd0;
        set_cfg(2'd3, 2'd0, 1'b0);
        pulses             = 0;
        got_data           = 8'h00;
        got_pe             = 1'b0;
        got_fe             = 1'b0;

        repeat (3) tick();
        chk("reset_tx", 32'(u_if.tx), 32'd1);
        chk("reset_tx_ready", 32'(u_if.tx_ready), 32'd1);
        chk("reset_tx_busy", 32'(u_if.tx_busy), 32'd0);
        chk("reset_rx_valid", 32'(u_if.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(u_if.rx_data), 32'd0);
        chk("reset_parity_err", 32'(u_if.rx_parity_err), 32'd0);
        chk("reset_frame_err", 32'(u_if.rx_frame_err), 32'd0);
        reset = 1'b0;
        tick();

        // Directed TX frames: 8N1 and 7E2 (bit 7 of 0xC1 is beyond the data width).
        send_frame(8'hA5, 2'd3, 2'd0, 1'b0, 1'b0);
        send_frame(8'hC1, 2'd2, 2'd1, 1'b1, 1'b0);

        // Loopback: 5O1 directed, then random formats including reserved parity code.
        loopback = 1'b1;
        send_frame(8'h1F, 2'd0, 2'd2, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'b1);
        end
        loopback = 1'b0;

        // Short low pulse on the line must be rejected.
        pulses = 0;
        rx_drv = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b1;
        repeat (60) tick();
        chk("glitch_no_valid", 32'(pulses), 32'd0);

        // 8N1 with stop bit low.
        set_cfg(2'd3, 2'd0, 1'b0);
        build_frame(8'h3C, 8, 0, 1'b0);
        frame_q[frame_q.size() - 1] = 1'b0;
        rx_frame(10, 0);
        chk("frame_err_pulses", 32'(pulses), 32'd1);
        chk("frame_err_data", 32'(got_data), 32'h3C);
        chk("frame_err_flag", 32'(got_fe), 32'd1);
        chk("frame_err_parity", 32'(got_pe), 32'd0);

        // 8E1 with the parity bit inverted.
        set_cfg(2'd3, 2'd1, 1'b0);
        d = 8'($urandom);
        build_frame(d, 8, 1, 1'b0);
        frame_q[9] = ~frame_q[9];
        rx_frame(10, 0);
        chk("parity_err_pulses", 32'(pulses), 32'd1);
        chk("parity_err_data", 32'(got_data), 32'(d));
        chk("parity_err_flag", 32'(got_pe), 32'd1);
        chk("parity_err_frame", 32'(got_fe), 32'd0);
        repeat (50) tick();
        chk("rx_data_hold", 32'(u_if.rx_data), 32'(d));

        // Break: line stays low after a framing error; only one frame is reported.
        set_cfg(2'd3, 2'd0, 1'b0);
        build_frame(8'h00, 8, 0, 1'b0);
        frame_q[frame_q.size() - 1] = 1'b0;
        rx_frame(10, 400);
        chk("break_pulses", 32'(pulses), 32'd1);
        chk("break_frame_err", 32'(got_fe), 32'd1);

        // Clean 6O2 frame after the break.
        set_cfg(2'd1, 2'd2, 1'b1);
        d = 8'($urandom);
        build_frame(d, 6, 2, 1'b1);
        rx_frame(10, 0);
        chk("post_break_pulses", 32'(pulses), 32'd1);
        chk("post_break_data", 32'(got_data), 32'(expect_data(d, 6)));
        chk("post_break_parity", 32'(got_pe), 32'd0);
        chk("post_break_frame", 32'(got_fe), 32'd0);

        // Reset in the middle of the data bits.
        set_cfg(2'd3, 2'd0, 1'b0);
        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b1;
        tick();
        u_if.tx_valid = 1'b0;
        repeat (40) tick();
        chk("mid_data_tx_low", 32'(u_if.tx), 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_reset_tx", 32'(u_if.tx), 32'd1);
        chk("mid_reset_tx_ready", 32'(u_if.tx_ready), 32'd1);
        chk("mid_reset_tx_busy", 32'(u_if.tx_busy), 32'd0);
        reset = 1'b0;
        tick();
        loopback = 1'b1;
        send_frame(8'h55, 2'd3, 2'd0, 1'b0, 1'b1);

        // Divisor 3: ticks every 4 clk; first tick phase depends on the free-running counter.
        u_if.cfg_divisor = 16'd3;
        set_cfg(2'd3, 2'd1, 1'b0);
        d = 8'($urandom);
        build_frame(d, 8, 1, 1'b0);
        len = frame_q.size();
        pulses = 0;
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        dur = 0;
        do begin
            tick();
            dur++;
            if (dur == 1) u_if.tx_valid = 1'b0;
        end while (u_if.tx_ready !== 1'b1 && dur < 64 * len + 100);
        dur = dur - 1;
        n_checks++;
        assert (dur >= 64 * len - 3 && dur <= 64 * len) else begin
            n_errors++;
            $error("FAIL div3_frame_clocks: observed=%0d expected=%0d..%0d", dur, 64 * len - 3, 64 * len);
        end
        repeat (40) tick();
        chk("div3_rx_pulses", 32'(pulses), 32'd1);
        chk("div3_rx_data", 32'(got_data), 32'(d));
        chk("div3_rx_parity", 32'(got_pe), 32'd0);
        u_if.cfg_divisor = 16'd0;
        loopback = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
